// File: rtl/pixel_stream_pkg.sv
// Shared state encoding and datapath widths for the pixel stream controller.
package pixel_stream_pkg;

  localparam int ADDR_W = 19;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 11;
  localparam int DLY_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_HBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/blank_counter.sv
// Down-counter for the vertical and horizontal blanking delays.
// A load arms it with the delay length. It counts down while enabled.
// tc flags the last cycle of the delay, and the count returns to zero
// as the owning state is left.
module blank_counter
  import pixel_stream_pkg::*;
(
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [DLY_W-1:0] load_value,
  output logic             tc
);

  logic [DLY_W-1:0] count;

  // Delay count register; clear wins over load, load wins over counting.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - DLY_W'(1);
    end
  end

  assign tc = enable && (count == DLY_W'(1));

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer for a pixel stream.
// The frame runs VSYNC, then HBLANK and ACTIVE for every line, then a
// single DONE cycle. ACTIVE issues one even/odd pixel pair per unstalled cycle.
module pixel_stream_ctrl
  import pixel_stream_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              busy,
  output logic              line_done,
  output logic              frame_done
);

  state_t state;
  state_t next_state;

  logic issue;
  logic end_of_line;
  logic last_row;
  logic abort_hit;
  logic vsync_load;
  logic hblank_load;
  logic vsync_tc;
  logic hblank_tc;

  assign abort_hit   = abort && (state != ST_IDLE);
  assign issue       = (state == ST_ACTIVE) && !stall;
  assign end_of_line = (col == COL_W'(WIDTH - 2));
  assign last_row    = (row == ROW_W'(HEIGHT - 1));

  // VSYNC length counter, armed on leaving IDLE.
  blank_counter u_vsync_cnt (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .clear      (abort_hit),
    .load       (vsync_load),
    .enable     (state == ST_VSYNC),
    .load_value (DLY_W'(START_UP_DELAY)),
    .tc         (vsync_tc)
  );

  // Per-line blanking counter, armed on every entry to HBLANK.
  blank_counter u_hblank_cnt (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .clear      (abort_hit),
    .load       (hblank_load),
    .enable     (state == ST_HBLANK),
    .load_value (DLY_W'(HSYNC_DELAY)),
    .tc         (hblank_tc)
  );

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and blanking-counter arming; abort overrides everything.
  always_comb begin
    next_state  = state;
    vsync_load  = 1'b0;
    hblank_load = 1'b0;
    if (abort_hit) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            next_state = ST_VSYNC;
            vsync_load = 1'b1;
          end
        end
        ST_VSYNC: begin
          if (vsync_tc) begin
            next_state  = ST_HBLANK;
            hblank_load = 1'b1;
          end
        end
        ST_HBLANK: begin
          if (hblank_tc) begin
            next_state = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (issue && end_of_line) begin
            if (last_row) begin
              next_state = ST_DONE;
            end else begin
              next_state  = ST_HBLANK;
              hblank_load = 1'b1;
            end
          end
        end
        ST_DONE: begin
          next_state = ST_IDLE;
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Pixel position; rd_addr runs linearly, so after the last pair of a line it already points at the next row.
  always_ff @(posedge HCLK) begin
    if (!HRESETn || abort_hit) begin
      rd_addr <= '0;
      row     <= '0;
      col     <= '0;
    end else if (state == ST_DONE) begin
      rd_addr <= '0;
      row     <= '0;
      col     <= '0;
    end else if (issue) begin
      rd_addr <= rd_addr + ADDR_W'(2);
      if (end_of_line) begin
        col <= '0;
        if (!last_row) begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(2);
      end
    end
  end

  assign VSYNC      = (state == ST_VSYNC);
  assign HSYNC      = issue;
  assign busy       = (state != ST_IDLE);
  assign line_done  = issue && end_of_line && !abort;
  assign frame_done = (state == ST_DONE) && !abort;

endmodule

// File: doc/pixel_stream_ctrl.md
PIXEL_STREAM_CTRL -- requirements
Module: pixel_stream_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 768: image width in pixels; even, at least 4.
REQ-002 SHALL have parameter HEIGHT, default 512: image height in lines; at least 1.
REQ-003 SHALL have parameter START_UP_DELAY, default 100: VSYNC length in cycles; range 1..511.
REQ-004 SHALL have parameter HSYNC_DELAY, default 160: blanking before each line in cycles; range 1..511.
REQ-005 SHALL have port HCLK, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port HRESETn, input, 1 bit: reset; synchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit: frame request; sampled only in IDLE.
REQ-008 SHALL have port abort, input, 1 bit: cancels the frame in progress.
REQ-009 SHALL have port stall, input, 1 bit: downstream not ready; freezes data issue.
REQ-010 SHALL have port VSYNC, output, 1 bit: high for the whole VSYNC state.
REQ-011 SHALL have port HSYNC, output, 1 bit: pair valid, i.e. rd_addr is issued this cycle.
REQ-012 SHALL have port rd_addr, output, 19 bits: pixel index of the even pixel, row*WIDTH+col.
REQ-013 SHALL have port row, output, 10 bits: current line; col, output, 11 bits: even-pixel column.
REQ-014 SHALL have ports busy, line_done and frame_done, each output, 1 bit.

Function
REQ-015 SHALL implement FSM states IDLE, VSYNC, HBLANK, ACTIVE, DONE, held in a registered state vector.
REQ-016 SHALL go IDLE->VSYNC on the cycle after start=1 is sampled in IDLE; start SHALL be ignored in every other state.
REQ-017 SHALL stay in VSYNC exactly START_UP_DELAY cycles, then enter HBLANK.
REQ-018 SHALL stay in HBLANK exactly HSYNC_DELAY cycles, then enter ACTIVE; delay counters SHALL be 9-bit and zero outside their state.
REQ-019 SHALL drive HSYNC = (state==ACTIVE && !stall) combinationally; rd_addr, row and col SHALL be valid whenever HSYNC=1.
REQ-020 SHALL, on each issued pair, advance col by 2 and rd_addr by 2; stall SHALL freeze col, row, rd_addr and state.
REQ-021 SHALL, when a pair issues at col==WIDTH-2, pulse line_done for that cycle, clear col, and take rd_addr to (row+1)*WIDTH.
REQ-022 SHALL, after that end-of-line pair, go to DONE if row==HEIGHT-1; otherwise it SHALL increment row and go to HBLANK.
REQ-023 SHALL assert frame_done for exactly the one DONE cycle, then go to IDLE; row and rd_addr SHALL clear to 0 on entering IDLE.
REQ-024 SHALL issue exactly WIDTH*HEIGHT/2 pairs per frame (196608 at defaults).
REQ-025 SHALL drive busy=1 in every state except IDLE.
REQ-026 SHALL, on abort=1 in any non-IDLE state, enter IDLE next cycle with counters cleared and no frame_done; abort SHALL take priority over stall and end-of-line.
REQ-027 SHALL, on stall=1 and abort=1 together, enter IDLE next cycle with HSYNC low.

Reset
REQ-028 SHALL, while HRESETn=0 at a clock edge, set state=IDLE and all counters=0.
REQ-029 SHALL hold outputs VSYNC, HSYNC, busy, line_done, frame_done at 0 and rd_addr, row, col at 0 during reset.
REQ-030 SHALL, on reset mid-frame, discard the frame silently; the first start after release SHALL begin a fresh frame.

Structure
REQ-031 SHALL place the state enum and the widths ADDR_W=19, ROW_W=10, COL_W=11, DLY_W=9 in shared package pixel_stream_pkg.
REQ-032 SHALL use one sub-module, blank_counter (load/enable/terminal-count), instantiated for the VSYNC and HBLANK delays.

Verification (WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2 unless noted)
REQ-033 SHALL check nominal frame: start at cycle 0 -> VSYNC at 1-3; HSYNC at 6-9, 12-15, 18-21, 24-27; rd_addr 0,2,4,6 then 8..14 and so on to 30; frame_done at 28; busy at 1-28.
REQ-034 SHALL check stall: stall=1 at cycles 7-8 -> HSYNC low at 7-8; rd_addr holds 2; row-0 pairs issue at 6, 9, 10, 11; line_done at 11.
REQ-035 SHALL check abort: abort at cycle 13 -> IDLE at 14, busy=0, no frame_done; a new start at 20 gives rd_addr=0 at 26.
REQ-036 SHALL check ignored start: start pulsed at cycles 5 and 20 -> no effect; exactly 16 pairs issued; frame_done once.
REQ-037 SHALL check mid-frame reset: HRESETn=0 at cycle 16 -> all outputs 0 at 17; start at 20 -> VSYNC at 21-23.
REQ-038 SHALL check defaults: one frame -> 196608 HSYNC pulses, 512 line_done pulses, last rd_addr=393214.
